// File: rtl/kbest_level_cache.sv
// kbest_level_cache: keeps the DEPTH best price levels of one book side,
// sorted best-first, and applies one add/subtract effect every two cycles.
module kbest_level_cache #(
  parameter int PRICE_BITS    = 32,
  parameter int QUANTITY_BITS = 32,
  parameter int DEPTH         = 5,
  parameter int IS_BID        = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_add,
  input  logic [PRICE_BITS-1:0]           in_price,
  input  logic [QUANTITY_BITS-1:0]        in_qty,
  output logic [DEPTH*PRICE_BITS-1:0]     lvl_price,
  output logic [DEPTH*QUANTITY_BITS-1:0]  lvl_total,
  output logic [DEPTH-1:0]                lvl_valid,
  output logic [$clog2(DEPTH+1)-1:0]      level_count,
  output logic [PRICE_BITS-1:0]           best_price,
  output logic [QUANTITY_BITS-1:0]        best_total,
  output logic                            best_valid,
  output logic                            upd_valid,
  output logic                            evict_valid,
  output logic [PRICE_BITS-1:0]           evict_price,
  output logic [QUANTITY_BITS-1:0]        evict_total,
  output logic                            drop_pulse,
  output logic                            miss_pulse,
  output logic                            sat_pulse
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t                    state_q;
  logic                      e_add_q;
  logic [PRICE_BITS-1:0]     e_price_q;
  logic [QUANTITY_BITS-1:0]  e_qty_q;

  logic [PRICE_BITS-1:0]     p_q [DEPTH];
  logic [QUANTITY_BITS-1:0]  t_q [DEPTH];
  logic [DEPTH-1:0]          v_q;
  logic [CW-1:0]             cnt_q;
  logic                      upd_q, evict_q, drop_q, miss_q, sat_q;
  logic [PRICE_BITS-1:0]     ev_p_q;
  logic [QUANTITY_BITS-1:0]  ev_t_q;

  logic [PRICE_BITS-1:0]     p_n [DEPTH];
  logic [QUANTITY_BITS-1:0]  t_n [DEPTH];
  logic [DEPTH-1:0]          v_n;
  logic [CW-1:0]             cnt_n;
  logic                      evict_n, drop_n, miss_n, sat_n;
  logic [PRICE_BITS-1:0]     ev_p_n;
  logic [QUANTITY_BITS-1:0]  ev_t_n;

  logic                      hit;
  int                        hit_idx;
  int                        ins_pos;
  logic [QUANTITY_BITS-1:0]  hit_total;
  logic [QUANTITY_BITS:0]    sum;

  function automatic logic better(input logic [PRICE_BITS-1:0] a,
                                  input logic [PRICE_BITS-1:0] b);
    return (IS_BID != 0) ? (a > b) : (a < b);
  endfunction

  assign in_ready = (state_q == IDLE);

  // Compute the level arrays and flags that the registered effect produces.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    hit       = 1'b0;
    hit_idx   = 0;
    hit_total = '0;
    ins_pos   = DEPTH;
    p_n       = p_q;
    t_n       = t_q;
    v_n       = v_q;
    cnt_n     = cnt_q;
    evict_n   = 1'b0;
    drop_n    = 1'b0;
    miss_n    = 1'b0;
    sat_n     = 1'b0;
    ev_p_n    = ev_p_q;
    ev_t_n    = ev_t_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i] && p_q[i] == e_price_q) begin
        hit       = 1'b1;
        hit_idx   = i;
        hit_total = t_q[i];
      end
    end
    // Valid levels are contiguous and sorted, so the first slot that is empty
    // or worse than the new price is the insertion point.
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!v_q[i] || better(e_price_q, p_q[i])) ins_pos = i;
    end
    sum = {1'b0, hit_total} + {1'b0, e_qty_q};

    if (e_qty_q == '0) begin
      // Zero quantity never changes the cache and raises no flag.
    end else if (e_add_q) begin
      if (hit) begin
        sat_n = sum[QUANTITY_BITS];
        for (int i = 0; i < DEPTH; i++) begin
          if (i == hit_idx) t_n[i] = sum[QUANTITY_BITS] ? '1 : sum[QUANTITY_BITS-1:0];
        end
      end else if (ins_pos < DEPTH) begin
        for (int i = 1; i < DEPTH; i++) begin
          if (i > ins_pos) begin
            p_n[i] = p_q[i-1];
            t_n[i] = t_q[i-1];
            v_n[i] = v_q[i-1];
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (i == ins_pos) begin
            p_n[i] = e_price_q;
            t_n[i] = e_qty_q;
            v_n[i] = 1'b1;
          end
        end
        if (cnt_q == CW'(DEPTH)) begin
          evict_n = 1'b1;
          ev_p_n  = p_q[DEPTH-1];
          ev_t_n  = t_q[DEPTH-1];
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end else begin
        drop_n = 1'b1;
      end
    end else begin
      if (!hit) begin
        miss_n = 1'b1;
      end else if (e_qty_q >= hit_total) begin
        for (int i = 0; i < DEPTH-1; i++) begin
          if (i >= hit_idx) begin
            p_n[i] = p_q[i+1];
            t_n[i] = t_q[i+1];
            v_n[i] = v_q[i+1];
          end
        end
        p_n[DEPTH-1] = '0;
        t_n[DEPTH-1] = '0;
        v_n[DEPTH-1] = 1'b0;
        cnt_n        = cnt_q - CW'(1);
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == hit_idx) t_n[i] = t_q[i] - e_qty_q;
        end
      end
    end
  end

  // FSM, effect capture and level storage; clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the level array is only DEPTH entries of flops, so it is reset
    // explicitly to give the zero-fill invalid slots must show.
    if (!rst_n) begin
      state_q   <= IDLE;
      e_add_q   <= 1'b0;
      e_price_q <= '0;
      e_qty_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        p_q[i] <= '0;
        t_q[i] <= '0;
      end
      v_q     <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      evict_q <= 1'b0;
      drop_q  <= 1'b0;
      miss_q  <= 1'b0;
      sat_q   <= 1'b0;
      ev_p_q  <= '0;
      ev_t_q  <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        p_q[i] <= '0;
        t_q[i] <= '0;
      end
      v_q     <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      evict_q <= 1'b0;
      drop_q  <= 1'b0;
      miss_q  <= 1'b0;
      sat_q   <= 1'b0;
      ev_p_q  <= '0;
      ev_t_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, whatever order these statements are written in.
      upd_q   <= 1'b0;
      evict_q <= 1'b0;
      drop_q  <= 1'b0;
      miss_q  <= 1'b0;
      sat_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            e_add_q   <= in_add;
            e_price_q <= in_price;
            e_qty_q   <= in_qty;
            state_q   <= APPLY;
          end
        end
        APPLY: begin
          p_q     <= p_n;
          t_q     <= t_n;
          v_q     <= v_n;
          cnt_q   <= cnt_n;
          upd_q   <= 1'b1;
          evict_q <= evict_n;
          drop_q  <= drop_n;
          miss_q  <= miss_n;
          sat_q   <= sat_n;
          ev_p_q  <= ev_p_n;
          ev_t_q  <= ev_t_n;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flatten the level registers onto the packed output buses.
  for (genvar g = 0; g < DEPTH; g++) begin : g_lvl
    assign lvl_price[g*PRICE_BITS +: PRICE_BITS]       = p_q[g];
    assign lvl_total[g*QUANTITY_BITS +: QUANTITY_BITS] = t_q[g];
  end

  assign lvl_valid   = v_q;
  assign level_count = cnt_q;
  assign best_price  = p_q[0];
  assign best_total  = t_q[0];
  assign best_valid  = v_q[0];
  assign upd_valid   = upd_q;
  assign evict_valid = evict_q;
  assign evict_price = ev_p_q;
  assign evict_total = ev_t_q;
  assign drop_pulse  = drop_q;
  assign miss_pulse  = miss_q;
  assign sat_pulse   = sat_q;

endmodule

// File: tb/tb_kbest_level_cache.sv
// Self-checking bench for kbest_level_cache: directed vector table, corner
// sequences (clear / reset mid-apply, ask side ordering) and random effects
// compared against a queue-based book model.
module tb_kbest_level_cache;

  localparam int PB = 32;
  localparam int QB = 32;
  localparam int D  = 5;
  localparam int CW = $clog2(D+1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear, in_valid, in_add;
  logic [PB-1:0]   in_price;
  logic [QB-1:0]   in_qty;
  logic            in_ready;
  logic [D*PB-1:0] lvl_price;
  logic [D*QB-1:0] lvl_total;
  logic [D-1:0]    lvl_valid;
  logic [CW-1:0]   level_count;
  logic [PB-1:0]   best_price, evict_price;
  logic [QB-1:0]   best_total, evict_total;
  logic            best_valid, upd_valid, evict_valid, drop_pulse, miss_pulse, sat_pulse;

  // Ask-side instance, used only for ordering.
  logic            a_clear, a_in_valid, a_in_add;
  logic [PB-1:0]   a_in_price;
  logic [QB-1:0]   a_in_qty;
  logic            a_in_ready;
  logic [D*PB-1:0] a_lvl_price;
  logic [D*QB-1:0] a_lvl_total;
  logic [D-1:0]    a_lvl_valid;
  logic [CW-1:0]   a_level_count;
  logic [PB-1:0]   a_best_price, a_evict_price;
  logic [QB-1:0]   a_best_total, a_evict_total;
  logic            a_best_valid, a_upd_valid, a_evict_valid, a_drop_pulse, a_miss_pulse, a_sat_pulse;

  always #5 clk = ~clk;

  kbest_level_cache #(.PRICE_BITS(PB), .QUANTITY_BITS(QB), .DEPTH(D), .IS_BID(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_add(in_add), .in_price(in_price), .in_qty(in_qty),
    .lvl_price(lvl_price), .lvl_total(lvl_total), .lvl_valid(lvl_valid),
    .level_count(level_count), .best_price(best_price), .best_total(best_total),
    .best_valid(best_valid), .upd_valid(upd_valid), .evict_valid(evict_valid),
    .evict_price(evict_price), .evict_total(evict_total), .drop_pulse(drop_pulse),
    .miss_pulse(miss_pulse), .sat_pulse(sat_pulse)
  );

  kbest_level_cache #(.PRICE_BITS(PB), .QUANTITY_BITS(QB), .DEPTH(D), .IS_BID(0)) u_ask (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_add(a_in_add), .in_price(a_in_price), .in_qty(a_in_qty),
    .lvl_price(a_lvl_price), .lvl_total(a_lvl_total), .lvl_valid(a_lvl_valid),
    .level_count(a_level_count), .best_price(a_best_price), .best_total(a_best_total),
    .best_valid(a_best_valid), .upd_valid(a_upd_valid), .evict_valid(a_evict_valid),
    .evict_price(a_evict_price), .evict_total(a_evict_total), .drop_pulse(a_drop_pulse),
    .miss_pulse(a_miss_pulse), .sat_pulse(a_sat_pulse)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: sorted queues, best first ----------------
  logic [31:0] mp[$];
  logic [31:0] mt[$];
  logic [31:0] m_evp, m_evt;
  bit          m_evict, m_drop, m_miss, m_sat;

  function automatic bit is_better(input logic [31:0] a, input logic [31:0] b);
    return a > b;
  endfunction

  task automatic model_reset();
    mp.delete();
    mt.delete();
    m_evp = 0;
    m_evt = 0;
  endtask

  task automatic model_apply(input bit add, input logic [31:0] price, input logic [31:0] qty);
    int idx = -1;
    int pos;
    longint unsigned s;
    m_evict = 0; m_drop = 0; m_miss = 0; m_sat = 0;
    for (int i = 0; i < mp.size(); i++) if (mp[i] == price) idx = i;
    if (qty == 0) return;
    if (add) begin
      if (idx >= 0) begin
        s = longint'(mt[idx]) + longint'(qty);
        if (s > 64'hFFFF_FFFF) begin
          mt[idx] = 32'hFFFF_FFFF;
          m_sat   = 1;
        end else begin
          mt[idx] = s[31:0];
        end
      end else begin
        pos = mp.size();
        for (int i = mp.size()-1; i >= 0; i--) if (is_better(price, mp[i])) pos = i;
        if (pos >= D) begin
          m_drop = 1;
        end else begin
          mp.insert(pos, price);
          mt.insert(pos, qty);
          if (mp.size() > D) begin
            m_evp = mp[D];
            m_evt = mt[D];
            void'(mp.pop_back());
            void'(mt.pop_back());
            m_evict = 1;
          end
        end
      end
    end else begin
      if (idx < 0) m_miss = 1;
      else if (qty >= mt[idx]) begin
        mp.delete(idx);
        mt.delete(idx);
      end else begin
        mt[idx] = mt[idx] - qty;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [D*PB-1:0] ep = '0;
    logic [D*QB-1:0] et = '0;
    logic [D-1:0]    ev = '0;
    for (int i = 0; i < mp.size(); i++) begin
      ep[i*PB +: PB] = mp[i];
      et[i*QB +: QB] = mt[i];
      ev[i] = 1'b1;
    end
    check({tag, ".lvl_price"}, lvl_price, ep);
    check({tag, ".lvl_total"}, lvl_total, et);
    check({tag, ".lvl_valid"}, lvl_valid, ev);
    check({tag, ".level_count"}, level_count, mp.size());
    check({tag, ".best"}, {best_valid, best_price, best_total}, {ev[0], ep[PB-1:0], et[QB-1:0]});
    check({tag, ".upd_valid"}, upd_valid, 1'b1);
    check({tag, ".flags"}, {evict_valid, drop_pulse, miss_pulse, sat_pulse},
          {m_evict, m_drop, m_miss, m_sat});
    check({tag, ".evict_regs"}, {evict_price, evict_total}, {m_evp, m_evt});
  endtask

  // Issue one effect starting at a negedge; returns at the negedge where the
  // update is visible (two cycles after the handshake) after model comparison.
  task automatic do_effect(input string tag, input bit add, input logic [31:0] price,
                           input logic [31:0] qty);
    int n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_add = add; in_price = price; in_qty = qty;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".busy"}, {in_ready, upd_valid}, 2'b00);
    @(negedge clk);
    model_apply(add, price, qty);
    compare_model(tag);
  endtask

  typedef struct {
    bit          add;
    logic [31:0] price;
    logic [31:0] qty;
    logic [31:0] bp;
    logic [31:0] bt;
    logic [2:0]  cnt;
    logic [3:0]  flags;  // {evict, drop, miss, sat}
  } vec_t;

  vec_t tbl[14];
  int   ask_p[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_add = 1'b0; in_price = '0; in_qty = '0;
    a_clear = 1'b0; a_in_valid = 1'b0; a_in_add = 1'b0; a_in_price = '0; a_in_qty = '0;
    model_reset();

    tbl[0]  = '{1'b1, 32'd100, 32'd10,         32'd100, 32'd10,         3'd1, 4'b0000};
    tbl[1]  = '{1'b1, 32'd102, 32'd5,          32'd102, 32'd5,          3'd2, 4'b0000};
    tbl[2]  = '{1'b1, 32'd101, 32'd7,          32'd102, 32'd5,          3'd3, 4'b0000};
    tbl[3]  = '{1'b1, 32'd103, 32'd1,          32'd103, 32'd1,          3'd4, 4'b0000};
    tbl[4]  = '{1'b1, 32'd104, 32'd1,          32'd104, 32'd1,          3'd5, 4'b0000};
    tbl[5]  = '{1'b1, 32'd106, 32'd2,          32'd106, 32'd2,          3'd5, 4'b1000};
    tbl[6]  = '{1'b1, 32'd90,  32'd4,          32'd106, 32'd2,          3'd5, 4'b0100};
    tbl[7]  = '{1'b0, 32'd102, 32'd3,          32'd106, 32'd2,          3'd5, 4'b0000};
    tbl[8]  = '{1'b0, 32'd102, 32'd9,          32'd106, 32'd2,          3'd4, 4'b0000};
    tbl[9]  = '{1'b0, 32'd77,  32'd1,          32'd106, 32'd2,          3'd4, 4'b0010};
    tbl[10] = '{1'b1, 32'd200, 32'hFFFF_FFF0,  32'd200, 32'hFFFF_FFF0,  3'd5, 4'b0000};
    tbl[11] = '{1'b1, 32'd200, 32'h20,         32'd200, 32'hFFFF_FFFF,  3'd5, 4'b0001};
    tbl[12] = '{1'b1, 32'd55,  32'd0,          32'd200, 32'hFFFF_FFFF,  3'd5, 4'b0000};
    tbl[13] = '{1'b0, 32'd200, 32'hFFFF_FFFF,  32'd106, 32'd2,          3'd4, 4'b0000};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.levels", {lvl_valid, level_count, best_valid}, '0);
    check("rst.arrays", {lvl_price, lvl_total}, '0);
    check("rst.pulses", {upd_valid, evict_valid, drop_pulse, miss_pulse, sat_pulse}, '0);
    check("rst.evict", {evict_price, evict_total}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready", in_ready, 1'b1);

    // Ask side: lower price is better.
    ask_p = '{100, 98, 99};
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1; a_in_add = 1'b1; a_in_price = ask_p[k]; a_in_qty = 32'd1;
      @(negedge clk);
      a_in_valid = 1'b0;
      @(negedge clk);
    end
    check("ask.order", a_lvl_price, {32'd0, 32'd0, 32'd100, 32'd99, 32'd98});
    check("ask.count", a_level_count, 3);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      do_effect($sformatf("vec%0d", i), tbl[i].add, tbl[i].price, tbl[i].qty);
      check($sformatf("vec%0d.tbl_best", i), {best_price, best_total}, {tbl[i].bp, tbl[i].bt});
      check($sformatf("vec%0d.tbl_count", i), level_count, tbl[i].cnt);
      check($sformatf("vec%0d.tbl_flags", i), {evict_valid, drop_pulse, miss_pulse, sat_pulse},
            tbl[i].flags);
      if (i == 2) begin
        check("vec2.prices", lvl_price[95:0], {32'd100, 32'd101, 32'd102});
        check("vec2.totals", lvl_total[95:0], {32'd10, 32'd7, 32'd5});
      end
    end
    check("tbl.evict_held", {evict_price, evict_total}, {32'd100, 32'd10});

    // Pulses last a single cycle.
    @(negedge clk);
    check("pulse.one_cycle", {upd_valid, evict_valid, drop_pulse, miss_pulse, sat_pulse}, '0);

    // Clear while an effect is in APPLY: discarded, no update.
    in_valid = 1'b1; in_add = 1'b1; in_price = 32'd300; in_qty = 32'd3;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check("clr.empty", {lvl_valid, level_count, lvl_price, lvl_total}, '0);
    check("clr.evict", {evict_price, evict_total}, '0);
    check("clr.ready_upd", {in_ready, upd_valid}, 2'b10);
    @(negedge clk);
    check("clr.no_upd", upd_valid, 1'b0);

    // in_valid together with clear is not accepted.
    in_valid = 1'b1; in_add = 1'b1; in_price = 32'd50; in_qty = 32'd1; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    check("clr_hs.ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    check("clr_hs.ignored", {upd_valid, level_count}, '0);

    // Async reset while in APPLY.
    do_effect("pre_rst", 1'b1, 32'd120, 32'd8);
    in_valid = 1'b1; in_add = 1'b1; in_price = 32'd130; in_qty = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst.immediate", {lvl_valid, level_count, best_valid, best_price}, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst.ready", in_ready, 1'b1);
    @(negedge clk);
    check("arst.no_upd1", upd_valid, 1'b0);
    @(negedge clk);
    check("arst.no_upd2", {upd_valid, level_count}, '0);

    // Random effects against the model.
    for (int r = 0; r < 300; r++) begin
      bit          add;
      logic [31:0] price, qty;
      int          sel;
      add   = ($urandom_range(0, 9) < 6);
      price = 32'd100 + $urandom_range(0, 11);
      sel   = $urandom_range(0, 19);
      if (sel == 0)      qty = 32'd0;
      else if (sel == 1) qty = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else               qty = $urandom_range(1, 20);
      do_effect($sformatf("rnd%0d", r), add, price, qty);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
